// File: rtl/rv32i_writeback.sv
// rv32i_writeback: last pipeline stage. It retires ALU results directly.
// For loads it waits for the data-memory ack, then extracts and extends the
// loaded byte or halfword. It drives a registered write port into the
// register file, and flags a load that times out.
module rv32i_writeback #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_flush,
    input  logic        i_opcode_load,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    input  logic        i_wr_rd,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_data,
    input  logic [31:0] i_data_load,
    input  logic        i_ack,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd,
    output logic        o_wr_rd,
    output logic        o_stall,
    output logic        o_load_err
);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lsb_q, lsb_d;
    logic [4:0]  prd_q, prd_d;
    logic        pwr_q, pwr_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_q, rd_d;
    logic        wr_rd_q, wr_rd_d;
    logic        load_err_q, load_err_d;
    logic        stall;

    // Select the addressed byte or halfword of the load word, then extend it.
    // LW and the unused codes pass the word through unchanged.
    function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3,
                                        input logic [1:0] lsb);
        logic [7:0]  b;
        logic [15:0] h;
        case (lsb)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lsb[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  ext = {{24{b[7]}}, b};
            3'b001:  ext = {{16{h[15]}}, h};
            3'b100:  ext = {24'd0, b};
            3'b101:  ext = {16'd0, h};
            default: ext = w;
        endcase
    endfunction

    // Next-state, stall and retire logic. Priority: reset, flush, ack, timeout, ce.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        f3_d       = f3_q;
        lsb_d      = lsb_q;
        prd_d      = prd_q;
        pwr_d      = pwr_q;
        rd_addr_d  = rd_addr_q;
        rd_d       = rd_q;
        wr_rd_d    = 1'b0;
        load_err_d = 1'b0;
        stall      = 1'b0;
        if (i_rst) begin
            state_d   = IDLE;
            cnt_d     = '0;
            rd_addr_d = '0;
            rd_d      = '0;
        end else if (i_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == WAIT_ACK) begin
            if (i_ack) begin
                rd_d      = ext(i_data_load, f3_q, lsb_q);
                rd_addr_d = prd_q;
                wr_rd_d   = pwr_q;
                state_d   = IDLE;
            end else if (cnt_q == CNT_LAST) begin
                stall      = 1'b1;
                load_err_d = 1'b1;
                state_d    = IDLE;
            end else begin
                stall = 1'b1;
                cnt_d = cnt_q + 16'd1;
            end
        end else if (i_ce) begin
            if (!i_opcode_load) begin
                rd_d      = i_rd_data;
                rd_addr_d = i_rd_addr;
                wr_rd_d   = i_wr_rd;
            end else if (i_ack) begin
                rd_d      = ext(i_data_load, i_funct3, i_addr_lsb);
                rd_addr_d = i_rd_addr;
                wr_rd_d   = i_wr_rd;
            end else begin
                // Park the load's fields until the memory answers.
                stall   = 1'b1;
                f3_d    = i_funct3;
                lsb_d   = i_addr_lsb;
                prd_d   = i_rd_addr;
                pwr_d   = i_wr_rd;
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
        end
    end

    // State, pending-load fields and registered regfile write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            f3_q       <= '0;
            lsb_q      <= '0;
            prd_q      <= '0;
            pwr_q      <= 1'b0;
            rd_addr_q  <= '0;
            rd_q       <= '0;
            wr_rd_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            f3_q       <= f3_d;
            lsb_q      <= lsb_d;
            prd_q      <= prd_d;
            pwr_q      <= pwr_d;
            rd_addr_q  <= rd_addr_d;
            rd_q       <= rd_d;
            wr_rd_q    <= wr_rd_d;
            load_err_q <= load_err_d;
        end
    end

    assign o_rd_addr  = rd_addr_q;
    assign o_rd       = rd_q;
    assign o_wr_rd    = wr_rd_q;
    assign o_load_err = load_err_q;
    assign o_stall    = stall;

endmodule

// File: tb/tb_rv32i_writeback.sv
// Bench for rv32i_writeback: directed cases followed by random traffic,
// all checked against a transaction-level model of the stage.
module tb_rv32i_writeback;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst, ce, flush, ld, wr, ack;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic [4:0]  rda;
    logic [31:0] rdd, dl;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd;
    logic        o_wr_rd, o_stall, o_load_err;

    int total = 0;
    int bad   = 0;

    // model state: one outstanding load at most
    bit          m_pend;
    logic [2:0]  m_f3;
    logic [1:0]  m_lsb;
    logic [4:0]  m_rda;
    bit          m_wr;
    int          m_waits;
    bit          e_wr, e_err;
    logic [4:0]  e_addr;
    logic [31:0] e_rd;

    always #5 clk = ~clk;

    rv32i_writeback #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_flush(flush),
        .i_opcode_load(ld), .i_funct3(f3), .i_addr_lsb(lsb), .i_wr_rd(wr),
        .i_rd_addr(rda), .i_rd_data(rdd), .i_data_load(dl), .i_ack(ack),
        .o_rd_addr(o_rd_addr), .o_rd(o_rd), .o_wr_rd(o_wr_rd),
        .o_stall(o_stall), .o_load_err(o_load_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // load extension written as arithmetic on the shifted word
    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] c,
                                            input logic [1:0] l);
        longint v;
        int sh;
        case (c)
            3'd0, 3'd4: begin
                v = longint'((w >> (8 * int'(l))) % 256);
                if (c == 3'd0 && v >= 128) v -= 256;
            end
            3'd1, 3'd5: begin
                sh = l[1] ? 16 : 0;
                v = longint'((w >> sh) % 65536);
                if (c == 3'd1 && v >= 32768) v -= 65536;
            end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    // One clock: drive, check stall, advance model, check registered outputs.
    task automatic cyc(input bit r, input bit c, input bit fl, input bit isld,
                       input logic [2:0] fn, input logic [1:0] lo, input bit w,
                       input logic [4:0] a, input logic [31:0] d, input logic [31:0] mem,
                       input bit k);
        bit exp_stall;
        @(negedge clk);
        rst = r; ce = c; flush = fl; ld = isld; f3 = fn; lsb = lo;
        wr = w; rda = a; rdd = d; dl = mem; ack = k;
        #1;
        if (r)           exp_stall = 0;
        else if (m_pend) exp_stall = !(fl || k);
        else             exp_stall = c && isld && !k && !fl;
        chk("stall", {31'd0, o_stall}, {31'd0, exp_stall});
        e_wr = 0; e_err = 0;
        if (r) begin
            m_pend = 0; e_addr = 0; e_rd = 0;
        end else if (fl) begin
            m_pend = 0;
        end else if (m_pend) begin
            m_waits++;
            if (k) begin
                e_rd = ref_ext(mem, m_f3, m_lsb); e_addr = m_rda; e_wr = m_wr; m_pend = 0;
            end else if (m_waits == TMO) begin
                e_err = 1; m_pend = 0;
            end
        end else if (c) begin
            if (!isld) begin
                e_rd = d; e_addr = a; e_wr = w;
            end else if (k) begin
                e_rd = ref_ext(mem, fn, lo); e_addr = a; e_wr = w;
            end else begin
                m_pend = 1; m_f3 = fn; m_lsb = lo; m_rda = a; m_wr = w; m_waits = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("wr_rd", {31'd0, o_wr_rd}, {31'd0, e_wr});
        chk("load_err", {31'd0, o_load_err}, {31'd0, e_err});
        chk("rd_addr", {27'd0, o_rd_addr}, {27'd0, e_addr});
        chk("rd", o_rd, e_rd);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 3'd0, 2'd0, 0, 5'd0, 32'd0, 32'd0, 0);
    endtask

    initial begin
        rst = 1; ce = 0; flush = 0; ld = 0; f3 = 0; lsb = 0;
        wr = 0; rda = 0; rdd = 0; dl = 0; ack = 0;
        cyc(1, 0, 0, 0, 3'd0, 2'd0, 0, 5'd0, 32'd0, 32'd0, 0);
        cyc(1, 1, 0, 1, 3'd2, 2'd0, 1, 5'd9, 32'd1, 32'd1, 0);
        chk("rst_rd", o_rd, 32'd0);
        chk("rst_addr", {27'd0, o_rd_addr}, 32'd0);
        chk("rst_wr", {31'd0, o_wr_rd}, 32'd0);

        // ALU op
        cyc(0, 1, 0, 0, 3'd0, 2'd0, 1, 5'd5, 32'hDEADBEEF, 32'd0, 0);
        chk("alu_rd", o_rd, 32'hDEADBEEF);
        chk("alu_addr", {27'd0, o_rd_addr}, 32'd5);
        chk("alu_wr", {31'd0, o_wr_rd}, 32'd1);

        // same-cycle ack loads
        cyc(0, 1, 0, 1, 3'd0, 2'd1, 1, 5'd3, 32'd0, 32'h00008000, 1);
        chk("lb", o_rd, 32'hFFFFFF80);
        cyc(0, 1, 0, 1, 3'd4, 2'd1, 1, 5'd3, 32'd0, 32'h00008000, 1);
        chk("lbu", o_rd, 32'h00000080);
        cyc(0, 1, 0, 1, 3'd1, 2'd2, 1, 5'd3, 32'd0, 32'h80010000, 1);
        chk("lh", o_rd, 32'hFFFF8001);

        // LW acked 3 cycles late, ce toggling while held
        cyc(0, 1, 0, 1, 3'd2, 2'd0, 1, 5'd7, 32'd0, 32'd0, 0);
        cyc(0, 0, 0, 0, 3'd0, 2'd0, 1, 5'd9, 32'h11, 32'd0, 0);
        cyc(0, 1, 0, 0, 3'd0, 2'd0, 1, 5'd9, 32'h22, 32'd0, 0);
        cyc(0, 1, 0, 0, 3'd0, 2'd0, 1, 5'd9, 32'h33, 32'h12345678, 1);
        chk("lw_late_rd", o_rd, 32'h12345678);
        chk("lw_late_addr", {27'd0, o_rd_addr}, 32'd7);
        idle();

        // timeout, then ack on the timeout cycle
        cyc(0, 1, 0, 1, 3'd2, 2'd0, 1, 5'd4, 32'd0, 32'd0, 0);
        repeat (TMO) idle();
        chk("tmo_err", {31'd0, o_load_err}, 32'd1);
        idle();
        cyc(0, 1, 0, 1, 3'd2, 2'd0, 1, 5'd4, 32'd0, 32'd0, 0);
        repeat (TMO - 1) idle();
        cyc(0, 0, 0, 0, 3'd0, 2'd0, 0, 5'd0, 32'd0, 32'hCAFEF00D, 1);
        chk("tmo_ack_wr", {31'd0, o_wr_rd}, 32'd1);
        chk("tmo_ack_err", {31'd0, o_load_err}, 32'd0);

        // flush in wait, late ack; flush with ce in idle
        cyc(0, 1, 0, 1, 3'd2, 2'd0, 1, 5'd6, 32'd0, 32'd0, 0);
        idle();
        cyc(0, 0, 1, 0, 3'd0, 2'd0, 0, 5'd0, 32'd0, 32'd0, 0);
        cyc(0, 0, 0, 0, 3'd0, 2'd0, 0, 5'd0, 32'd0, 32'h5, 1);
        chk("flush_wr", {31'd0, o_wr_rd}, 32'd0);
        cyc(0, 1, 1, 0, 3'd0, 2'd0, 1, 5'd8, 32'h77, 32'd0, 0);
        chk("flush_ce_wr", {31'd0, o_wr_rd}, 32'd0);

        // reset mid-wait, then an ALU op
        cyc(0, 1, 0, 1, 3'd2, 2'd0, 1, 5'd6, 32'd0, 32'd0, 0);
        cyc(1, 0, 0, 0, 3'd0, 2'd0, 0, 5'd0, 32'd0, 32'd0, 1);
        chk("rst_wait_rd", o_rd, 32'd0);
        cyc(0, 1, 0, 0, 3'd0, 2'd0, 1, 5'd2, 32'hA5A5A5A5, 32'd0, 0);
        chk("post_rst_rd", o_rd, 32'hA5A5A5A5);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 60,
                3'($urandom), 2'($urandom), 1'($urandom), 5'($urandom),
                $urandom, $urandom, $urandom_range(0, 99) < 25);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
